mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Two-requester arbiter sharing the single Data_Memory port (256-bit line, enable/write/ack handshake)
//  between port 0 (instruction cache refill) and port 1 (dcache refill/write-back). Sits between the
//  caches inside CPU and the external Data_Memory; one transaction in flight, round-robin on ties,
//  watchdog on missing memory ack.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   256  cache-line width
//  TIMEOUT  64   cycles in GNT without mem_ack_i before abort; 0 disables watchdog
// PORTS
//  clk_i         in   1       clock, all state on rising edge
//  rst_i         in   1       reset, asynchronous, active-high
//  m0_enable_i   in   1       port 0 request; held with addr/data/write until m0_ack_o
//  m0_write_i    in   1       port 0: 1=write line, 0=read line
//  m0_addr_i     in   ADDR_W  port 0 byte address
//  m0_data_i     in   DATA_W  port 0 write data
//  m0_ack_o      out  1       port 0 done, 1-cycle pulse
//  m0_data_o     out  DATA_W  port 0 read data, valid with m0_ack_o
//  m1_*          --   --      identical set for port 1
//  mem_enable_o  out  1       to Data_Memory enable_i
//  mem_write_o   out  1       to Data_Memory write_i
//  mem_addr_o    out  ADDR_W  to Data_Memory addr_i
//  mem_data_o    out  DATA_W  to Data_Memory data_i
//  mem_ack_i     in   1       from Data_Memory ack_o
//  mem_data_i    in   DATA_W  from Data_Memory data_o
//  grant_o       out  2       one-hot owner {m1,m0}; 00 when no owner
//  timeout_o     out  1       sticky watchdog flag
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, last_q=1 (port 0 wins first tie), wdog=0, timeout_o=0;
//   all outputs 0 while rst_i high, irrespective of clock.
//  States: IDLE, GNT0, GNT1, GAP.
//  IDLE: at edge, only m0_enable_i -> GNT0; only m1 -> GNT1; both -> port != last_q; none -> stay.
//  GNTx: mem_enable_o=1; mem_write/addr/data = owner's inputs (comb mux); grant_o one-hot owner.
//   Latency: request sampled at edge k, mem_enable_o high right after edge k.
//   mem_ack_i=1 -> mx_ack_o=1 and mx_data_o=mem_data_i same cycle (comb); at edge: last_q=x, ->GAP.
//   Other port's request held pending; never preempts.
//  GAP: exactly 1 cycle, mem_enable_o=0, grant_o=00, requests ignored (served port may still hold
//   enable this cycle); -> IDLE. Back-to-back service interval: ack cycle + GAP + IDLE edge.
//  Non-owner/idle: mx_ack_o=0, mx_data_o=0; mem_write/addr/data_o=0 when no owner.
//  mem_ack_i in IDLE or GAP: ignored, never forwarded.
//  Watchdog: wdog counts edges in GNTx, cleared on entry. TIMEOUT!=0 and wdog==TIMEOUT-1 with no
//   ack -> GAP, no ack to requester, timeout_o=1 (sticky until reset), last_q=x so a waiting other
//   port wins next; aborted port retries by holding enable.
//  Ack on same edge as watchdog expiry: ack wins, timeout_o unchanged.
//  wdog width clog2(TIMEOUT+1), saturates, never wraps.
// TESTING
//  1 m0 read addr 0x20, mem acks 10 cycles later data 0xAB..AB -> m0_ack_o 1 cycle with data, grant 01, GAP, IDLE.
//  2 m0,m1 both request from reset -> m0 served first, m1 next; both again -> m0 then m1; strict alternation.
//  3 m1 write addr 0x400 in flight, m0 arrives -> mem_addr_o stays 0x400 until ack; m0 granted 2 edges after.
//  4 mem_ack_i pulsed in IDLE and in GAP -> m0_ack_o=m1_ack_o=0, state unchanged.
//  5 TIMEOUT=16, m1 request, no ack -> GAP after 16 GNT cycles, timeout_o=1 and stays; m1 re-granted.
//  6 rst_i asserted mid-GNT0 between edges -> mem_enable_o, grant_o drop to 0 at once; after release m0 re-arbitrated.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the Data_Memory port and the arbiter status
// lines. The arbiter uses the slave view; the CPU side and memory model use master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);
  // Requester port 0 (instruction cache refill)
  logic              m0_enable_i;
  logic              m0_write_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_data_i;
  logic              m0_ack_o;
  logic [DATA_W-1:0] m0_data_o;
  // Requester port 1 (dcache refill / write-back)
  logic              m1_enable_i;
  logic              m1_write_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_data_i;
  logic              m1_ack_o;
  logic [DATA_W-1:0] m1_data_o;
  // Data_Memory side
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;
  // Status
  logic [1:0]        grant_o;
  logic              timeout_o;

  modport slave (
    input  m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
    input  m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
    input  mem_ack_i, mem_data_i,
    output m0_ack_o, m0_data_o, m1_ack_o, m1_data_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output grant_o, timeout_o
  );

  modport master (
    output m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
    output m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
    output mem_ack_i, mem_data_i,
    input  m0_ack_o, m0_data_o, m1_ack_o, m1_data_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single Data_Memory line port. One transaction
// in flight, round-robin on simultaneous requests, one dead cycle (GAP) after each
// transaction, and a watchdog that aborts a grant whose memory ack never arrives.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 64
) (
  input logic           clk_i,
  input logic           rst_i,
  mem_arbiter_if.slave  bus
);

  localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;        // port served most recently; loses the next tie
  logic              timeout_q, timeout_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              owner0, owner1, wdog_expire;

  assign owner0      = (state_q == GNT0);
  assign owner1      = (state_q == GNT1);
  assign wdog_expire = (TIMEOUT != 0) && (wdog_q == WDOG_LAST);

  // State, tie-break history, sticky timeout flag and watchdog counter.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the combinational block below uses blocking assignments.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
    end
  end

  // Next-state logic: arbitration in IDLE, ack or watchdog abort in GNTx, one-cycle GAP.
  // NOTE: every variable gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    timeout_d = timeout_q;
    wdog_d    = '0;
    case (state_q)
      IDLE: begin
        if (bus.m0_enable_i && (!bus.m1_enable_i || last_q)) state_d = GNT0;
        else if (bus.m1_enable_i)                             state_d = GNT1;
      end
      GNT0, GNT1: begin
        wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + 1'b1;
        // Ack takes priority over a coincident watchdog expiry.
        if (bus.mem_ack_i) begin
          state_d = GAP;
          last_d  = owner1;
        end else if (wdog_expire) begin
          state_d   = GAP;
          last_d    = owner1;
          timeout_d = 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port follows the current owner; all zero when nobody owns it.
  assign bus.mem_enable_o = owner0 | owner1;
  assign bus.mem_write_o  = (owner0 & bus.m0_write_i) | (owner1 & bus.m1_write_i);
  assign bus.mem_addr_o   = owner0 ? bus.m0_addr_i : (owner1 ? bus.m1_addr_i : '0);
  assign bus.mem_data_o   = owner0 ? bus.m0_data_i : (owner1 ? bus.m1_data_i : '0);

  // Ack and read data are forwarded combinationally to the owner only.
  assign bus.m0_ack_o  = owner0 & bus.mem_ack_i;
  assign bus.m1_ack_o  = owner1 & bus.mem_ack_i;
  assign bus.m0_data_o = bus.m0_ack_o ? bus.mem_data_i : '0;
  assign bus.m1_data_o = bus.m1_ack_o ? bus.mem_data_i : '0;

  assign bus.grant_o   = {owner1, owner0};
  assign bus.timeout_o = timeout_q;

endmodule
